// File: rtl/animation_pkg.sv
// Shared constants and state encoding for the note-lane animation blocks.
// Screen geometry, palette codes and the square_drawer FSM state type.
package animation_pkg;

    localparam logic [8:0] SCREEN_W = 9'd160;
    localparam logic [7:0] SCREEN_H = 8'd120;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] BLUE   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } draw_state_e;

endpackage

// File: rtl/square_drawer_pixel_counter.sv
// Row-major col/row counter for one SIZE x SIZE square (col fastest).
// Presents the next position so the owner can register pixels ahead of the count.
module pixel_counter #(
    parameter int SIZE = 4,
    localparam int CW = $clog2(SIZE),
    localparam int IW = 2 * CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [CW-1:0] col_next_o,
    output logic [CW-1:0] row_next_o,
    output logic          last_o
);

    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    // SIZE is a power of two, so a single index splits cleanly into row | col.
    assign idx_d      = idx_q + IW'(1);
    assign col_next_o = idx_d[CW-1:0];
    assign row_next_o = idx_d[IW-1:CW];
    assign last_o     = &idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else if (clr_i) begin
            idx_q <= '0;
        end else if (en_i) begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/square_drawer.sv
// Walks a SIZE x SIZE pixel block into the VGA adapter write port, one pixel per clock.
// Optional one-entry request buffer enabled by defining SQUARE_DRAWER_QUEUE_EN.
//
// state   | meaning
// IDLE    | waiting for plot; ready=1
// DRAW    | one pixel per cycle from the base registers
// DONE    | one-cycle done pulse, no write
module square_drawer
    import animation_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       plot,
    input  logic [7:0] starting_x,
    input  logic [6:0] starting_y,
    input  logic [2:0] colour,
    output logic       ready,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour_out,
    output logic       writeEn,
    output logic       done
);

    localparam int CW = $clog2(SIZE);

    draw_state_e state_q, state_d;
    logic [7:0]  base_x_q;
    logic [6:0]  base_y_q;
    logic [2:0]  base_c_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [2:0]  colour_q;
    logic        we_q, done_q;

    logic          start, cnt_en, cnt_clr, emit, done_d;
    logic [7:0]    src_x;
    logic [6:0]    src_y;
    logic [2:0]    src_c;
    logic [CW-1:0] pix_col, pix_row, col_next, row_next;
    logic          last;
    logic [8:0]    sum_x;
    logic [7:0]    sum_y;
    logic          on_screen;

`ifdef SQUARE_DRAWER_QUEUE_EN
    logic       pend_valid_q;
    logic [7:0] pend_x_q;
    logic [6:0] pend_y_q;
    logic [2:0] pend_c_q;
    logic       pend_load, pend_clr;

    assign ready     = (state_q == ST_IDLE) || !pend_valid_q;
    assign pend_load = (state_q == ST_DRAW) && plot && !pend_valid_q;
`else
    assign ready = (state_q == ST_IDLE);
`endif

    pixel_counter #(.SIZE(SIZE)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .en_i      (cnt_en),
        .clr_i     (cnt_clr),
        .col_next_o(col_next),
        .row_next_o(row_next),
        .last_o    (last)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        emit    = 1'b0;
        done_d  = 1'b0;
        src_x   = base_x_q;
        src_y   = base_y_q;
        src_c   = base_c_q;
        pix_col = col_next;
        pix_row = row_next;
`ifdef SQUARE_DRAWER_QUEUE_EN
        pend_clr = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (plot) begin
                    start = 1'b1;
                    src_x = starting_x;
                    src_y = starting_y;
                    src_c = colour;
                end
            end
            ST_DRAW: begin
                if (last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    emit   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef SQUARE_DRAWER_QUEUE_EN
                // Chain straight into the next square so back-to-back costs SIZE*SIZE+1.
                if (pend_valid_q) begin
                    start    = 1'b1;
                    pend_clr = 1'b1;
                    src_x    = pend_x_q;
                    src_y    = pend_y_q;
                    src_c    = pend_c_q;
                end else if (plot) begin
                    start = 1'b1;
                    src_x = starting_x;
                    src_y = starting_y;
                    src_c = colour;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_DRAW;
            cnt_clr = 1'b1;
            emit    = 1'b1;
            pix_col = '0;
            pix_row = '0;
        end
    end

    // Sums are one bit wider so a wrapped coordinate is still seen as off-screen.
    assign sum_x     = {1'b0, src_x} + {{(9-CW){1'b0}}, pix_col};
    assign sum_y     = {1'b0, src_y} + {{(8-CW){1'b0}}, pix_row};
    assign on_screen = (sum_x < SCREEN_W) && (sum_y < SCREEN_H);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            base_x_q <= '0;
            base_y_q <= '0;
            base_c_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                base_x_q <= src_x;
                base_y_q <= src_y;
                base_c_q <= src_c;
            end
            if (emit) begin
                x_q      <= sum_x[7:0];
                y_q      <= sum_y[6:0];
                colour_q <= src_c;
            end
            we_q   <= emit && on_screen;
            done_q <= done_d;
        end
    end

`ifdef SQUARE_DRAWER_QUEUE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_c_q     <= '0;
        end else if (pend_clr) begin
            pend_valid_q <= 1'b0;
        end else if (pend_load) begin
            pend_valid_q <= 1'b1;
            pend_x_q     <= starting_x;
            pend_y_q     <= starting_y;
            pend_c_q     <= colour;
        end
    end
`endif

    assign x          = x_q;
    assign y          = y_q;
    assign colour_out = colour_q;
    assign writeEn    = we_q;
    assign done       = done_q;

endmodule

// File: tb/tb_square_drawer.sv
// Directed bench for square_drawer: pixel walk, clipping, input hold-off, async reset, erase.
// The buffered-request section only runs when SQUARE_DRAWER_QUEUE_EN is defined.
module tb_square_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic       plot;
    logic [7:0] starting_x;
    logic [6:0] starting_y;
    logic [2:0] colour;
    logic       ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour_out;
    logic       writeEn;
    logic       done;

    int n_pass  = 0;
    int n_total = 0;

    square_drawer #(.SIZE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .plot      (plot),
        .starting_x(starting_x),
        .starting_y(starting_y),
        .colour    (colour),
        .ready     (ready),
        .x         (x),
        .y         (y),
        .colour_out(colour_out),
        .writeEn   (writeEn),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a request before the next rising edge; it is accepted on that edge.
    task automatic request(input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] c,
                           input bit hold);
        plot       = 1'b1;
        starting_x = sx;
        starting_y = sy;
        starting_x = sx;
        colour     = c;
        @(posedge clk);
        #1;
        if (!hold) plot = 1'b0;
    endtask

    // Called just after the accept edge: checks 16 pixels, the done cycle and the return to ready.
    task automatic expect_square(input string tag, input logic [7:0] sx, input logic [6:0] sy,
                                 input logic [2:0] c, input bit scramble);
        for (int k = 0; k < 16; k++) begin
            int ex, ey;
            logic exp_we;
            ex     = int'(sx) + (k % 4);
            ey     = int'(sy) + (k / 4);
            exp_we = (ex < 160) && (ey < 120);
            @(negedge clk);
            chk($sformatf("%s we[%0d]", tag, k), writeEn, exp_we);
            chk($sformatf("%s done[%0d]", tag, k), done, 0);
`ifndef SQUARE_DRAWER_QUEUE_EN
            chk($sformatf("%s ready[%0d]", tag, k), ready, 0);
`endif
            if (exp_we) begin
                chk($sformatf("%s x[%0d]", tag, k), x, ex & 8'hff);
                chk($sformatf("%s y[%0d]", tag, k), y, ey & 7'h7f);
                chk($sformatf("%s col[%0d]", tag, k), colour_out, c);
            end
            @(posedge clk);
            #1;
            if (scramble) begin
                starting_x = 8'($urandom);
                starting_y = 7'($urandom);
                colour     = 3'($urandom);
            end
        end
        @(negedge clk);
        chk({tag, " done pulse"}, done, 1);
        chk({tag, " done we"}, writeEn, 0);
        chk({tag, " done ready"}, ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, " done end"}, done, 0);
        chk({tag, " ready back"}, ready, 1);
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk({tag, " done seen"}, i < 40, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        plot       = 1'b0;
        starting_x = '0;
        starting_y = '0;
        colour     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", ready, 1);
        chk("rst we", writeEn, 0);
        chk("rst done", done, 0);
        chk("rst x", x, 0);
        chk("rst y", y, 0);
        chk("rst colour", colour_out, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic red square.
        request(8'd10, 7'd112, 3'b100, 1'b0);
        expect_square("t1", 8'd10, 7'd112, 3'b100, 1'b0);

        // Bottom-right corner: only a 2x2 quarter lands on screen.
        request(8'd158, 7'd118, 3'b010, 1'b0);
        expect_square("t2", 8'd158, 7'd118, 3'b010, 1'b0);

        // Erase path.
        request(8'd40, 7'd50, 3'b000, 1'b0);
        expect_square("t6", 8'd40, 7'd50, 3'b000, 1'b0);

`ifndef SQUARE_DRAWER_QUEUE_EN
        // plot held high, inputs churn during DRAW; then the held request is taken once ready.
        request(8'd30, 7'd20, 3'b001, 1'b1);
        expect_square("t3a", 8'd30, 7'd20, 3'b001, 1'b1);
        request(8'd50, 7'd60, 3'b110, 1'b0);
        expect_square("t3b", 8'd50, 7'd60, 3'b110, 1'b0);
`endif

        // Async reset at pixel 7.
        request(8'd5, 7'd5, 3'b100, 1'b0);
        repeat (7) @(posedge clk);
        #2;
        chk("t4 pre x", x, 8'd8);
        reset = 1'b1;
        #1;
        chk("t4 async we", writeEn, 0);
        chk("t4 async x", x, 0);
        chk("t4 async y", y, 0);
        chk("t4 async col", colour_out, 0);
        chk("t4 async ready", ready, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("t4 no done[%0d]", k), done, 0);
            chk($sformatf("t4 idle we[%0d]", k), writeEn, 0);
        end
        chk("t4 ready after", ready, 1);
        request(8'd70, 7'd0, 3'b010, 1'b0);
        expect_square("t4b", 8'd70, 7'd0, 3'b010, 1'b0);

`ifdef SQUARE_DRAWER_QUEUE_EN
        // Buffered second request chains directly after DONE; third waits for the buffer.
        request(8'd0, 7'd0, 3'b100, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5 ready draw", ready, 1);
        request(8'd20, 7'd10, 3'b110, 1'b1);
        starting_x = 8'd100;
        starting_y = 7'd100;
        colour     = 3'b001;
        @(negedge clk);
        chk("t5 buffer full", ready, 0);
        wait_done("t5a");
        chk("t5 ready in done", ready, 0);
        @(negedge clk);
        chk("t5 b we0", writeEn, 1);
        chk("t5 b x0", x, 8'd20);
        chk("t5 b y0", y, 7'd10);
        chk("t5 b col0", colour_out, 3'b110);
        chk("t5 ready freed", ready, 1);
        @(posedge clk);
        #1;
        plot = 1'b0;
        @(negedge clk);
        chk("t5 c buffered", ready, 0);
        chk("t5 b x1", x, 8'd21);
        wait_done("t5b");
        @(negedge clk);
        chk("t5 c we0", writeEn, 1);
        chk("t5 c x0", x, 8'd100);
        chk("t5 c y0", y, 7'd100);
        chk("t5 c col0", colour_out, 3'b001);
        wait_done("t5c");
        @(negedge clk);
        chk("t5 idle ready", ready, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
